// File: rtl/ram_pkg.sv
// Shared definitions for the RAM request controller: bus widths,
// command op-codes and the controller state encoding.
package ram_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RESP,
    ST_WRITE,
    ST_FILL,
    ST_ERR
  } state_t;

endpackage

// File: rtl/ram_initiator_if.sv
// Client-facing command/response bundle of the RAM controller.
// The master side is the client issuing commands; the slave side is the controller.
interface ram_initiator_if;
  import ram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_add;
  logic [DATA_W-1:0] req_data;
  logic [ADDR_W-1:0] req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              done;
  logic              err;
  logic              busy;

  modport master (
    output req_valid, req_op, req_add, req_data, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, done, err, busy
  );

  modport slave (
    input  req_valid, req_op, req_add, req_data, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, done, err, busy
  );

endinterface

// File: rtl/ram_addr_counter.sv
// Address and remaining-word counter for the RAM controller.
// The address wraps modulo 2^ADDR_W; 'last' flags the final word of a fill.
module ram_addr_counter
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_add,
  input  logic [ADDR_W-1:0] load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] count;

  // Load start address and length on accept, then advance one word per step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr  <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= load_add;
      count <= load_len;
    end else if (step) begin
      addr  <= addr + ADDR_W'(1);
      count <= count - ADDR_W'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/ram_initiator.sv
// Request-side controller for the 16K x 16 RAM macro. Accepts read, write
// and block-fill commands, sequences the RAM strobes and returns read data.
// Every output comes from a register so request inputs never reach the RAM
// strobes combinationally.
module ram_initiator
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  ram_initiator_if.slave    bus,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_en
);

  state_t            state;
  state_t            state_n;
  logic              load;
  logic              step;
  logic              capture;
  logic              last;
  logic              rsp_valid_n;
  logic              done_n;
  logic              err_n;
  logic [DATA_W-1:0] data_q;
  logic              ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              done_q;
  logic              err_q;

  ram_addr_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .load_add (bus.req_add),
    .load_len (bus.req_len),
    .addr     (mem_add),
    .last     (last)
  );

  // Next-state and next-output decisions for the command sequencer
  always_comb begin
    state_n     = state;
    load        = 1'b0;
    step        = 1'b0;
    capture     = 1'b0;
    rsp_valid_n = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          load = 1'b1;
          case (bus.req_op)
            OP_READ:  state_n = ST_READ;
            OP_WRITE: state_n = ST_WRITE;
            OP_FILL:  state_n = ST_FILL;
            default:  state_n = ST_ERR;
          endcase
        end
      end
      ST_READ: begin
        capture     = 1'b1;
        rsp_valid_n = 1'b1;
        state_n     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_n = ST_IDLE;
        end else begin
          rsp_valid_n = 1'b1;
        end
      end
      ST_WRITE: begin
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      ST_FILL: begin
        if (last) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          step = 1'b1;
        end
      end
      ST_ERR: begin
        done_n  = 1'b1;
        err_n   = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register plus registered strobes derived from the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      mem_en      <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      ready_q     <= (state_n == ST_IDLE);
      busy_q      <= (state_n != ST_IDLE);
      mem_en      <= (state_n == ST_READ) || (state_n == ST_WRITE) || (state_n == ST_FILL);
      mem_read    <= (state_n == ST_READ);
      mem_write   <= (state_n == ST_WRITE) || (state_n == ST_FILL);
      rsp_valid_q <= rsp_valid_n;
      done_q      <= done_n;
      err_q       <= err_n;
    end
  end

  // Latch write data / fill pattern on accept and capture read data at end of READ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      if (load) begin
        data_q <= bus.req_data;
      end
      if (capture) begin
        rsp_data_q <= mem_out;
      end
    end
  end

  assign mem_in        = data_q;
  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ram_initiator.sv
// Testbench for ram_initiator: directed vector table, hand-written corner
// sequences and randomized commands checked against a word-array model.
module tb_ram_initiator;
  import ram_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [13:0] add;
    logic [15:0] data;
    logic [13:0] len;
    int          hold;
    logic [15:0] exp_rsp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [13:0] mem_add;
  logic [15:0] mem_in;
  logic [15:0] mem_out;
  logic        mem_read;
  logic        mem_write;
  logic        mem_en;

  logic [15:0] ram     [0:16383];
  logic [15:0] ref_mem [0:16383];

  int n_checks;
  int n_fail;

  ram_initiator_if bus();

  ram_initiator dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_add   (mem_add),
    .mem_in    (mem_in),
    .mem_out   (mem_out),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_en    (mem_en)
  );

  // Free-running system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM macro: asynchronous read, write at rising edge
  always @(posedge clk) begin
    if (mem_en && mem_write) ram[mem_add] <= mem_in;
  end

  // Read port of the RAM macro
  always_comb begin
    mem_out = 16'h0000;
    if (mem_en && mem_read) mem_out = ram[mem_add];
  end

  // Global watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Presents a command at a negedge and waits (bounded) for the accepting edge
  task automatic applyStimulus(input logic [1:0] op, input logic [13:0] add, input logic [15:0] data,
                               input logic [13:0] len, output time t_acc);
    logic rdy;
    bit   ok;
    ok            = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_add   = add;
    bus.req_data  = data;
    bus.req_len   = len;
    for (int c = 0; c < 64 && !ok; c++) begin
      rdy = bus.req_ready;
      @(posedge clk);
      if (rdy) ok = 1'b1;
      else @(negedge clk);
    end
    t_acc = $time;
    #1;
    bus.req_valid = 1'b0;
    bus.req_add   = 14'($urandom);
    bus.req_data  = 16'($urandom);
    bus.req_len   = 14'($urandom);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got no accept, want accept within 64 cycles");
    end
  endtask

  // Runs one complete command and checks the cycle-by-cycle behaviour against the model
  task automatic runCmd(input logic [1:0] op, input logic [13:0] add, input logic [15:0] data,
                        input logic [13:0] len, input int hold, output logic [15:0] rd);
    time         t;
    int          errs;
    logic [13:0] a;
    rd = 16'h0000;
    applyStimulus(op, add, data, len, t);
    case (op)
      OP_WRITE: begin
        @(negedge clk);
        checkOutput("wr_strobe", 32'({mem_en, mem_write, mem_read, bus.done, bus.req_ready, bus.busy}), 32'(6'b110001));
        checkOutput("wr_add", 32'(mem_add), 32'(add));
        checkOutput("wr_in", 32'(mem_in), 32'(data));
        ref_mem[add] = data;
        @(negedge clk);
        checkOutput("wr_done", 32'({bus.done, bus.err, bus.req_ready, bus.busy, mem_write}), 32'(5'b10100));
      end
      OP_FILL: begin
        errs = 0;
        for (int k = 0; k <= int'(len); k++) begin
          @(negedge clk);
          a = 14'((int'(add) + k) % 16384);
          if ({mem_en, mem_write, mem_read, bus.done, bus.busy} !== 5'b11001 || mem_add !== a || mem_in !== data)
            errs++;
          ref_mem[a] = data;
        end
        checkOutput("fill_stream_errs", 32'(errs), 32'(0));
        @(negedge clk);
        checkOutput("fill_done", 32'({bus.done, bus.err, bus.req_ready, bus.busy, mem_write}), 32'(5'b10100));
      end
      OP_READ: begin
        @(negedge clk);
        checkOutput("rd_strobe", 32'({mem_en, mem_read, mem_write, bus.rsp_valid, bus.req_ready, bus.busy}), 32'(6'b110001));
        checkOutput("rd_add", 32'(mem_add), 32'(add));
        for (int h = 0; h <= hold; h++) begin
          @(negedge clk);
          checkOutput("rsp_flags", 32'({bus.rsp_valid, bus.req_ready, bus.busy, mem_en}), 32'(4'b1010));
          checkOutput("rsp_data", 32'(bus.rsp_data), 32'(ref_mem[add]));
          bus.rsp_ready = (h == hold);
        end
        rd = bus.rsp_data;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_release", 32'({bus.rsp_valid, bus.req_ready, bus.busy}), 32'(3'b010));
      end
      default: begin
        @(negedge clk);
        checkOutput("err_idle_mem", 32'({mem_en, mem_write, mem_read, bus.done, bus.err, bus.busy, bus.req_ready}), 32'(7'b0000010));
        @(negedge clk);
        checkOutput("err_pulse", 32'({bus.done, bus.err, bus.busy, bus.req_ready}), 32'(4'b1101));
        @(negedge clk);
        checkOutput("err_pulse_end", 32'({bus.done, bus.err}), 32'(2'b00));
      end
    endcase
  endtask

  initial begin
    vec_t        vecs [11];
    logic [15:0] rd;
    time         t0;
    time         t1;
    int          errs;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16384; i++) begin
      ram[i]     = 16'(i) ^ 16'hA5A5;
      ref_mem[i] = 16'(i) ^ 16'hA5A5;
    end

    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_add   = '0;
    bus.req_data  = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b0;
    reset         = 1'b1;

    #3;
    checkOutput("reset_flags", 32'({bus.req_ready, bus.rsp_valid, bus.done, bus.err, bus.busy, mem_read, mem_write, mem_en}), 32'(8'b10000000));
    checkOutput("reset_mem_add", 32'(mem_add), 32'(0));
    checkOutput("reset_mem_in", 32'(mem_in), 32'(0));
    checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    vecs[0]  = '{OP_WRITE, 14'h0005, 16'hBEEF, 14'd0, 0, 16'h0000};
    vecs[1]  = '{OP_READ,  14'h0005, 16'h0000, 14'd0, 0, 16'hBEEF};
    vecs[2]  = '{OP_FILL,  14'h3FFE, 16'h1234, 14'd3, 0, 16'h0000};
    vecs[3]  = '{OP_READ,  14'h3FFE, 16'h0000, 14'd0, 1, 16'h1234};
    vecs[4]  = '{OP_READ,  14'h0001, 16'h0000, 14'd0, 0, 16'h1234};
    vecs[5]  = '{OP_READ,  14'h0002, 16'h0000, 14'd0, 2, 16'hA5A7};
    vecs[6]  = '{OP_READ,  14'h3FFD, 16'h0000, 14'd0, 0, 16'h9A58};
    vecs[7]  = '{OP_RSVD,  14'h0123, 16'hFFFF, 14'd7, 0, 16'h0000};
    vecs[8]  = '{OP_READ,  14'h0005, 16'h0000, 14'd0, 5, 16'hBEEF};
    vecs[9]  = '{OP_WRITE, 14'h3FFF, 16'h0F0F, 14'd0, 0, 16'h0000};
    vecs[10] = '{OP_READ,  14'h3FFF, 16'h0000, 14'd0, 0, 16'h0F0F};

    for (int i = 0; i < 11; i++) begin
      runCmd(vecs[i].op, vecs[i].add, vecs[i].data, vecs[i].len, vecs[i].hold, rd);
      if (vecs[i].op == OP_READ) checkOutput("vec_rsp", 32'(rd), 32'(vecs[i].exp_rsp));
    end

    $display("[TB] stalled second command during held response");
    applyStimulus(OP_READ, 14'h0005, 16'h0000, 14'd0, t0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_WRITE;
    bus.req_add   = 14'h0077;
    bus.req_data  = 16'h7777;
    bus.req_len   = 14'd0;
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      checkOutput("stall_flags", 32'({bus.rsp_valid, bus.req_ready, mem_write}), 32'(3'b100));
      checkOutput("stall_data", 32'(bus.rsp_data), 32'(16'hBEEF));
      bus.rsp_ready = (h == 5);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkOutput("stall_release", 32'({bus.rsp_valid, bus.req_ready, mem_write}), 32'(3'b010));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("stall_write_go", 32'({mem_write, mem_en}), 32'(2'b11));
    checkOutput("stall_write_add", 32'(mem_add), 32'(14'h0077));
    checkOutput("stall_write_in", 32'(mem_in), 32'(16'h7777));
    ref_mem[14'h0077] = 16'h7777;
    @(negedge clk);
    checkOutput("stall_write_done", 32'(bus.done), 32'(1));

    $display("[TB] back-to-back writes");
    applyStimulus(OP_WRITE, 14'h0010, 16'h1111, 14'd0, t0);
    ref_mem[14'h0010] = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    checkOutput("b2b_first_done", 32'({bus.done, bus.req_ready}), 32'(2'b11));
    applyStimulus(OP_WRITE, 14'h0011, 16'h2222, 14'd0, t1);
    ref_mem[14'h0011] = 16'h2222;
    checkOutput("b2b_spacing", 32'(t1 - t0), 32'(20));
    @(negedge clk);
    checkOutput("b2b_second_wr", 32'({mem_write, bus.done}), 32'(2'b10));
    checkOutput("b2b_second_add", 32'(mem_add), 32'(14'h0011));
    @(negedge clk);
    checkOutput("b2b_second_done", 32'(bus.done), 32'(1));

    $display("[TB] reset in the middle of a fill");
    applyStimulus(OP_FILL, 14'h0100, 16'h5A5A, 14'd99, t0);
    repeat (10) @(posedge clk);
    #2;
    checkOutput("midfill_active", 32'({mem_write, bus.busy}), 32'(2'b11));
    reset = 1'b1;
    #1;
    checkOutput("midfill_reset", 32'({mem_write, mem_en, bus.busy, bus.done, bus.req_ready}), 32'(5'b00001));
    for (int k = 0; k < 10; k++) ref_mem[14'h0100 + 14'(k)] = 16'h5A5A;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midfill_no_done", 32'(bus.done), 32'(0));
    runCmd(OP_READ, 14'h0109, 16'h0000, 14'd0, 0, rd);
    checkOutput("midfill_last", 32'(rd), 32'(16'h5A5A));
    runCmd(OP_READ, 14'h010A, 16'h0000, 14'd0, 0, rd);
    checkOutput("midfill_untouched", 32'(rd), 32'(16'hA4AF));

    $display("[TB] full-array fill from an unaligned start");
    runCmd(OP_FILL, 14'h1234, 16'hC3C3, 14'd16383, 0, rd);

    $display("[TB] randomized commands");
    for (int i = 0; i < 40; i++) begin
      runCmd(2'($urandom_range(0, 3)), 14'($urandom_range(0, 16383)), 16'($urandom),
             14'($urandom_range(0, 20)), int'($urandom_range(0, 3)), rd);
    end

    errs = 0;
    for (int i = 0; i < 16384; i++) begin
      if (ram[i] !== ref_mem[i]) errs++;
    end
    checkOutput("mem_image_errs", 32'(errs), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
